// File: rtl/execution_muldiv_control_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer: op codes,
// sequencer states and the iteration-counter width helper.
package execution_muldiv_control_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic int unsigned md_cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/execution_muldiv_step.sv
// One iteration of the sequencer datapath: a shift-add multiply step or a
// restoring divide step on the {acc_hi, acc_lo} working pair.
import execution_muldiv_control_pkg::*;

module execution_muldiv_step #(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_sub;

  // Multiply: acc_lo holds the unconsumed multiplier bits, product shifts right.
  assign sum = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, operand_i} : '0);

  // Divide: partial remainder always stays below the divisor, so the trial
  // difference fits in WIDTH bits whenever the subtraction succeeds.
  assign shifted = {acc_hi_i, acc_lo_i[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, operand_i});
  assign rem_sub = shifted[WIDTH-1:0] - operand_i;

  always_comb begin
    acc_hi_o = acc_hi_i;
    acc_lo_o = acc_lo_i;
    if (is_div_i) begin
      acc_hi_o = fits ? rem_sub : shifted[WIDTH-1:0];
      acc_lo_o = {acc_lo_i[WIDTH-2:0], fits};
    end else begin
      acc_hi_o = sum[WIDTH:1];
      acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/execution_muldiv_control.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; iterates on
// magnitudes one bit per clock and applies sign correction in FIX.
import execution_muldiv_control_pkg::*;

module execution_muldiv_control #(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = md_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             neg_res_q, neg_res_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             start_signed;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             is_div, is_signed;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign start_signed = (md_op_e'(op) == OP_MULT) || (md_op_e'(op) == OP_DIV);
  assign rs_neg = start_signed & rs_data[WIDTH-1];
  assign rt_neg = start_signed & rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;

  assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  execution_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i  (is_div),
    .acc_hi_i  (acc_hi_q),
    .acc_lo_i  (acc_lo_q),
    .operand_i (operand_q),
    .acc_hi_o  (step_hi),
    .acc_lo_o  (step_lo)
  );

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (is_signed && neg_res_q) ? -prod : prod;
  assign quo_fix  = (is_signed && neg_res_q) ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = rem_neg_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    count_d    = count_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    operand_d  = operand_q;
    neg_res_d  = neg_res_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mthi) hi_d = rs_data;
        if (mtlo) lo_d = rs_data;
        if (start) begin
          op_d       = md_op_e'(op);
          acc_hi_d   = '0;
          acc_lo_d   = rs_mag;
          operand_d  = rt_mag;
          neg_res_d  = rs_neg ^ rt_neg;
          rem_neg_d  = rs_neg;
          div_zero_d = (rt_data == '0);
          count_d    = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        count_d  = count_q + 1'b1;
        if (count_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div) begin
          // Divide by zero leaves an all-ones quotient; keep it unsigned-looking.
          hi_d = rem_fix;
          lo_d = div_zero_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_MULTU;
      count_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      operand_q  <= '0;
      neg_res_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      count_q    <= count_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      operand_q  <= operand_d;
      neg_res_q  <= neg_res_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_execution_muldiv_control.sv
// Directed bench for execution_muldiv_control: hand-computed HI/LO results,
// latency/busy timing, MT writes, ignored mid-run inputs and async reset.
module tb_execution_muldiv_control;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec  = 0;
  int n_miss = 0;

  execution_muldiv_control #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one op; inputs change on negedges, samples taken on negedges.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input bit perturb);
    int  k;
    int  bcnt;
    bit  seen;
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; bcnt = 0; seen = 1'b0;
    while (k < 40 && !seen) begin
      if (busy) bcnt++;
      if (done) seen = 1'b1;
      else begin
        if (perturb && k == 5) begin
          start = 1'b1; mtlo = 1'b1; mthi = 1'b1;
          op = 2'b10; rs_data = 32'h5555_5555; rt_data = 32'h0000_0001;
        end
        if (perturb && k == 6) begin
          start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
        end
        k++;
        @(negedge clk);
      end
    end
    chk_val({tag, " latency"}, 64'(k), 64'd33);
    chk_val({tag, " busy_cycles"}, 64'(bcnt), 64'd33);
    chk_val({tag, " hi"}, 64'(hi), 64'(ehi));
    chk_val({tag, " lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
    chk_val({tag, " done_low_after"}, 64'(done), 64'd0);
    chk_val({tag, " busy_low_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0;
    #23;
    chk_val("reset busy", 64'(busy), 64'd0);
    chk_val("reset done", 64'(done), 64'd0);
    chk_val("reset hi", 64'(hi), 64'd0);
    chk_val("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MT writes in IDLE
    @(negedge clk);
    rs_data = 32'hAAAA_0000; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    chk_val("mthi hi", 64'(hi), 64'h0000_0000_AAAA_0000);
    chk_val("mthi lo_untouched", 64'(lo), 64'd0);
    rs_data = 32'h0000_1357; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    chk_val("mtlo lo", 64'(lo), 64'h0000_1357);
    chk_val("mtlo hi_untouched", 64'(hi), 64'h0000_0000_AAAA_0000);
    rs_data = 32'h0000_2468; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk_val("mt_both hi", 64'(hi), 64'h0000_2468);
    chk_val("mt_both lo", 64'(lo), 64'h0000_2468);

    run_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_m3x7",  2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("divu_100_7", 2'b10, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0);
    run_op("div_m7_2",   2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_m2",   2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("div_by0",    2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_pert",  2'b10, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b1);
    run_op("multu_pert", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 32'h000B_000F, 1'b1);

    // async reset in the middle of RUN
    @(negedge clk);
    op = 2'b00; rs_data = 32'h1234_5678; rt_data = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk_val("pre_rst busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_val("async_rst busy", 64'(busy), 64'd0);
    chk_val("async_rst done", 64'(done), 64'd0);
    chk_val("async_rst hi", 64'(hi), 64'd0);
    chk_val("async_rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'h0000_0000, 32'd42, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
